// File: rtl/reg_file_sb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : reg_file_sb_pkg
// Brief   : Shared constants for the register file / write-pending scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
package reg_file_sb_pkg;

    // Same address width as the destination-select mux that drives wa.
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;
    localparam int unsigned N_REGS     = 2 ** REG_ADDR_W;
    localparam int unsigned REG_ZERO   = 0;

endpackage : reg_file_sb_pkg
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : reg_scoreboard
// Brief   : Busy-bit vector tracking in-flight register writes, with
//           reset/flush/set/clear priority and writeback-masked busy outputs.
// Revision: 1.0 - initial release
// ============================================================================
module reg_scoreboard
    import reg_file_sb_pkg::*;
#(
    parameter int N = REG_ADDR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] rs_addr,
    input  logic [N-1:0] rt_addr,
    input  logic [N-1:0] iss_dst,
    input  logic         set_en,
    input  logic         we,
    input  logic [N-1:0] wa,
    input  logic         flush,
    output logic         rs_busy,
    output logic         rt_busy,
    output logic         dst_busy
);

    localparam int            NUM  = 2 ** N;
    localparam logic [N-1:0]  ZERO = N'(REG_ZERO);

    logic [NUM-1:0] busy;
    logic [NUM-1:0] set_vec;
    logic [NUM-1:0] clr_vec;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (set_en && (iss_dst != ZERO)) begin
            set_vec[iss_dst] = 1'b1;
        end
        if (we && (wa != ZERO)) begin
            clr_vec[wa] = 1'b1;
        end
    end

    // Set is OR-ed in after the clear so a new writer keeps the register busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            busy <= set_vec | (busy & ~clr_vec);
        end
    end

    always_comb begin
        rs_busy  = busy[rs_addr] & ~(we & (wa == rs_addr));
        rt_busy  = busy[rt_addr] & ~(we & (wa == rt_addr));
        dst_busy = busy[iss_dst] & ~(we & (wa == iss_dst));
    end

endmodule : reg_scoreboard
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module  : reg_file_sb
// Brief   : 2-read/1-write register file with write-first bypass and an
//           integrated write-pending scoreboard driving the issue stall.
// Revision: 1.0 - initial release
// ============================================================================
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int N = REG_ADDR_W,
    parameter int W = REG_DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] rs_addr,
    input  logic [N-1:0] rt_addr,
    output logic [W-1:0] rs_data,
    output logic [W-1:0] rt_data,
    input  logic         we,
    input  logic [N-1:0] wa,
    input  logic [W-1:0] wd,
    input  logic         iss_valid,
    input  logic         iss_wr,
    input  logic [N-1:0] iss_dst,
    input  logic         flush,
    output logic         rs_busy,
    output logic         rt_busy,
    output logic         stall
);

    localparam int           NUM  = 2 ** N;
    localparam logic [N-1:0] ZERO = N'(REG_ZERO);

    logic [W-1:0] regs [NUM];
    logic         dst_busy;
    logic         accept;
    logic         set_en;

    // Register 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != ZERO)) begin
            regs[wa] <= wd;
        end
    end

    always_comb begin
        if (rs_addr == ZERO) begin
            rs_data = '0;
        end else if (we && (wa == rs_addr)) begin
            rs_data = wd;
        end else begin
            rs_data = regs[rs_addr];
        end
    end

    always_comb begin
        if (rt_addr == ZERO) begin
            rt_data = '0;
        end else if (we && (wa == rt_addr)) begin
            rt_data = wd;
        end else begin
            rt_data = regs[rt_addr];
        end
    end

    // Busy outputs do not depend on set_en, so the accept feedback is acyclic.
    always_comb begin
        stall  = iss_valid & (rs_busy | rt_busy | (iss_wr & dst_busy));
        accept = iss_valid & ~stall;
        set_en = accept & iss_wr;
    end

    reg_scoreboard #(
        .N (N)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .iss_dst  (iss_dst),
        .set_en   (set_en),
        .we       (we),
        .wa       (wa),
        .flush    (flush),
        .rs_busy  (rs_busy),
        .rt_busy  (rt_busy),
        .dst_busy (dst_busy)
    );

endmodule : reg_file_sb
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module  : tb_reg_file_sb
// Brief   : Self-checking bench for reg_file_sb against an array-based model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_reg_file_sb;

    logic        clk;
    logic        rst;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        iss_valid;
    logic        iss_wr;
    logic [4:0]  iss_dst;
    logic        flush;
    logic        rs_busy;
    logic        rt_busy;
    logic        stall;

    int total;
    int bad;

    logic [31:0] mreg  [32];
    bit          mbusy [32];

    reg_file_sb dut (
        .clk       (clk),
        .rst       (rst),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .iss_valid (iss_valid),
        .iss_wr    (iss_wr),
        .iss_dst   (iss_dst),
        .flush     (flush),
        .rs_busy   (rs_busy),
        .rt_busy   (rt_busy),
        .stall     (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (we && wa == a) return wd;
        return mreg[a];
    endfunction

    function automatic bit exp_busy(input logic [4:0] a);
        return mbusy[a] && !(we && wa == a);
    endfunction

    function automatic bit exp_stall();
        return iss_valid && (exp_busy(rs_addr) || exp_busy(rt_addr) || (iss_wr && exp_busy(iss_dst)));
    endfunction

    // Applies the next-edge rules to the model using the inputs currently driven.
    task automatic model_update();
        bit acc;
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                mreg[i]  = 32'd0;
                mbusy[i] = 1'b0;
            end
        end else begin
            acc = iss_valid && !exp_stall();
            if (we && wa != 5'd0) mreg[wa] = wd;
            if (flush) begin
                for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
            end else begin
                if (we && wa != 5'd0) mbusy[wa] = 1'b0;
                if (acc && iss_wr && iss_dst != 5'd0) mbusy[iss_dst] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; rs_addr = 0; rt_addr = 0; we = 0; wa = 0; wd = 0;
        iss_valid = 0; iss_wr = 0; iss_dst = 0; flush = 0;
    endtask

    task automatic issue(input logic [4:0] dst);
        idle();
        iss_valid = 1; iss_wr = 1; iss_dst = dst;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++; $display("FAIL issue_accept dst=%0d: stall=%b want 0", dst, stall);
        end
        tick();
    endtask

    task automatic test_reset();
        idle();
        rst = 1; we = 1; wa = 5'd3; wd = 32'hDEAD_BEEF;
        iss_valid = 1; iss_wr = 1; iss_dst = 5'd4;
        tick();
        tick();
        idle();
        for (int a = 0; a < 32; a++) begin
            rs_addr = 5'(a); rt_addr = 5'(31 - a);
            #1;
            total++;
            if (rs_data !== 32'd0 || rt_data !== 32'd0) begin
                bad++; $display("FAIL reset_data a=%0d: rs=%h rt=%h want 0", a, rs_data, rt_data);
            end
            total++;
            if (rs_busy !== 1'b0 || rt_busy !== 1'b0 || stall !== 1'b0) begin
                bad++; $display("FAIL reset_busy a=%0d: rs_busy=%b rt_busy=%b stall=%b want 0", a, rs_busy, rt_busy, stall);
            end
            tick();
        end
        we = 1; wa = 5'd0; wd = 32'hFFFF_FFFF; rs_addr = 5'd0;
        #1;
        total++;
        if (rs_data !== 32'd0) begin
            bad++; $display("FAIL reg0_bypass: got %h want 0", rs_data);
        end
        tick();
        idle();
        #1;
        total++;
        if (rs_data !== 32'd0) begin
            bad++; $display("FAIL reg0_store: got %h want 0", rs_data);
        end
    endtask

    task automatic test_bypass();
        idle();
        we = 1; wa = 5'd5; wd = 32'h1234_5678; rs_addr = 5'd5; rt_addr = 5'd6;
        #1;
        total++;
        if (rs_data !== 32'h1234_5678) begin
            bad++; $display("FAIL bypass_same_cycle: got %h want 12345678", rs_data);
        end
        total++;
        if (rt_data !== 32'd0) begin
            bad++; $display("FAIL bypass_other_port: got %h want 0", rt_data);
        end
        tick();
        we = 0; wd = 32'h0BAD_0BAD; rt_addr = 5'd5;
        #1;
        total++;
        if (rs_data !== 32'h1234_5678 || rt_data !== 32'h1234_5678) begin
            bad++; $display("FAIL stored_read: rs=%h rt=%h want 12345678", rs_data, rt_data);
        end
        tick();
    endtask

    task automatic test_raw();
        logic [31:0] v;
        issue(5'd7);
        idle();
        iss_valid = 1; rs_addr = 5'd7;
        #1;
        total++;
        if (rs_busy !== 1'b1 || stall !== 1'b1) begin
            bad++; $display("FAIL raw_stall: rs_busy=%b stall=%b want 1 1", rs_busy, stall);
        end
        tick();
        v = $urandom;
        we = 1; wa = 5'd7; wd = v;
        #1;
        total++;
        if (rs_busy !== 1'b0 || stall !== 1'b0 || rs_data !== v) begin
            bad++; $display("FAIL raw_release: rs_busy=%b stall=%b data=%h want 0 0 %h", rs_busy, stall, rs_data, v);
        end
        tick();
    endtask

    task automatic test_waw();
        issue(5'd9);
        idle();
        iss_valid = 1; iss_wr = 1; iss_dst = 5'd9;
        #1;
        total++;
        if (stall !== 1'b1) begin
            bad++; $display("FAIL waw_stall: stall=%b want 1", stall);
        end
        tick();
        we = 1; wa = 5'd9; wd = 32'h0000_0099;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++; $display("FAIL set_wins_accept: stall=%b want 0", stall);
        end
        tick();
        idle();
        rt_addr = 5'd9;
        #1;
        total++;
        if (rt_busy !== 1'b1) begin
            bad++; $display("FAIL set_wins_busy: rt_busy=%b want 1", rt_busy);
        end
        tick();
    endtask

    task automatic test_flush();
        issue(5'd3);
        issue(5'd4);
        issue(5'd10);
        idle();
        rs_addr = 5'd3; rt_addr = 5'd10;
        #1;
        total++;
        if (rs_busy !== 1'b1 || rt_busy !== 1'b1) begin
            bad++; $display("FAIL flush_pre: rs_busy=%b rt_busy=%b want 1 1", rs_busy, rt_busy);
        end
        idle();
        flush = 1; iss_valid = 1; iss_wr = 1; iss_dst = 5'd12;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++; $display("FAIL flush_issue: stall=%b want 0", stall);
        end
        tick();
        idle();
        for (int a = 0; a < 32; a += 2) begin
            rs_addr = 5'(a); rt_addr = 5'(a + 1);
            #1;
            total++;
            if (rs_busy !== 1'b0 || rt_busy !== 1'b0) begin
                bad++; $display("FAIL flush_clear a=%0d: rs_busy=%b rt_busy=%b want 0 0", a, rs_busy, rt_busy);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        idle();
        we = 1; wa = 5'd2; wd = 32'hA5A5_A5A5;
        tick();
        issue(5'd2);
        issue(5'd6);
        idle();
        rst = 1; we = 1; wa = 5'd2; wd = 32'h5A5A_5A5A;
        tick();
        idle();
        iss_valid = 1; iss_wr = 1; iss_dst = 5'd6; rs_addr = 5'd2; rt_addr = 5'd6;
        #1;
        total++;
        if (rs_data !== 32'd0) begin
            bad++; $display("FAIL reset_mid_data: got %h want 0", rs_data);
        end
        total++;
        if (rs_busy !== 1'b0 || rt_busy !== 1'b0 || stall !== 1'b0) begin
            bad++; $display("FAIL reset_mid_busy: rs_busy=%b rt_busy=%b stall=%b want 0", rs_busy, rt_busy, stall);
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(0, 59) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            rs_addr   = 5'($urandom_range(0, 7));
            rt_addr   = 5'($urandom_range(0, 7));
            we        = ($urandom_range(0, 1) == 1);
            wa        = 5'($urandom_range(0, 7));
            wd        = $urandom;
            iss_valid = ($urandom_range(0, 4) < 3);
            iss_wr    = ($urandom_range(0, 9) < 7);
            iss_dst   = 5'($urandom_range(0, 7));
            if (c % 50 == 0) rs_addr = 5'($urandom_range(0, 31));
            #1;
            total++;
            if (rs_data !== exp_data(rs_addr) || rt_data !== exp_data(rt_addr)) begin
                bad++; $display("FAIL rand_data c=%0d: rs=%h rt=%h want %h %h", c, rs_data, rt_data, exp_data(rs_addr), exp_data(rt_addr));
            end
            total++;
            if (rs_busy !== exp_busy(rs_addr) || rt_busy !== exp_busy(rt_addr)) begin
                bad++; $display("FAIL rand_busy c=%0d: rs_busy=%b rt_busy=%b want %b %b", c, rs_busy, rt_busy, exp_busy(rs_addr), exp_busy(rt_addr));
            end
            total++;
            if (stall !== exp_stall()) begin
                bad++; $display("FAIL rand_stall c=%0d: stall=%b want %b", c, stall, exp_stall());
            end
            tick();
        end
        idle();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 32; i++) begin
            mreg[i]  = 32'd0;
            mbusy[i] = 1'b0;
        end
        idle();
        @(negedge clk);
        test_reset();
        test_bypass();
        test_raw();
        test_waw();
        test_flush();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_reg_file_sb
`default_nettype wire

// File: doc/reg_file_sb.md
# reg_file_sb

Register file with an integrated write-pending scoreboard. It sits directly downstream of the 5-bit destination-select multiplexer: the mux output drives `wa`, and `wd` carries the writeback data. The block supplies two combinational read ports with same-cycle write bypass. It tracks which registers have an in-flight write and raises `stall` so issue logic holds dependent instructions.

## Interface
- `n`, 5: register address width; `2**n` registers.
- `W`, 32: data width.

- `clk` in 1: clock, all state updates on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `rs_addr` in n: read port A address.
- `rt_addr` in n: read port B address.
- `rs_data` out W: read port A data (combinational).
- `rt_data` out W: read port B data (combinational).
- `we` in 1: writeback enable.
- `wa` in n: writeback address (from destination mux).
- `wd` in W: writeback data.
- `iss_valid` in 1: an instruction requests issue this cycle.
- `iss_wr` in 1: issuing instruction will write a register.
- `iss_dst` in n: its destination register.
- `flush` in 1: discard all pending writes (clear scoreboard).
- `rs_busy` out 1: source A has a pending write not satisfied this cycle.
- `rt_busy` out 1: source B has a pending write not satisfied this cycle.
- `stall` out 1: issue blocked this cycle.

## Operation
- **Storage:** `2**n` x W registers. Register 0 always reads 0. Writes to register 0 are ignored. Register 0 is never marked busy.
- **Write:** on a rising edge, if `we` and `wa != 0`, then `reg[wa] <= wd`. At the same time, `busy[wa]` is cleared.
- **Read:** `rs_data` is `wd` when `we & wa==rs_addr & rs_addr!=0`. Otherwise it is `reg[rs_addr]` (write-first bypass). `rt_data` follows the same rule with `rt_addr`.
- **Busy (outputs):** `rs_busy = busy[rs_addr] & ~(we & wa==rs_addr)`. `rt_busy` follows the same rule. A same-cycle writeback therefore satisfies a dependency.
- **Stall:** `stall = iss_valid & (rs_busy | rt_busy | (iss_wr & dst_busy))`.
  - `dst_busy` uses the same bypass-masked rule on `iss_dst`.
  - A busy destination blocks issue (WAW hazard). Only one pending write per register is allowed.
- **Issue accept:** `iss_valid & ~stall`. If also `iss_wr & iss_dst!=0`, then `busy[iss_dst]` is set at the next edge.
- **Simultaneous set and clear on the same register:** set wins. The register stays busy for the new writer.
- **Flush:** clears every busy bit at the next edge. Register contents are unaffected.
  - A same-cycle `we` still writes data.
  - A same-cycle accepted issue does not set busy (flush wins over set).
- **Writeback to a non-busy register:** permitted. Data is written and busy stays 0.
- **Reset:** all registers 0, all busy bits 0. `rst` overrides `we`, `iss_*` and `flush` in the same cycle.
- **Outputs after reset:**
  - `rs_data = rt_data = 0` unless bypass is active.
  - `rs_busy = rt_busy = 0`.
  - `stall = 0`.

## Timing
- Read latency 0: combinational from address, or from `we`/`wa`/`wd` via the bypass path.
- Write visible through bypass in the same cycle. Visible from storage from the cycle after the edge.
- Busy set: the first cycle after the accepting edge.
- Busy clear: the writeback cycle itself (via masking), and in storage from the next edge.
- `stall` is purely combinational. There is no registered hazard state beyond the busy bits.
- `rst` asserted mid-operation discards all pending writes. The first cycle after deassertion behaves as post-reset.

## Structure
- **Shared package:** `N_REGS = 2**n`, `REG_ZERO = 0`, and the default `n`/`W` constants. Reuse the same `n` as the destination mux.
- **Sub-module `reg_scoreboard`:**
  - Holds the busy vector.
  - Performs set/clear/flush/reset priority.
  - Produces the bypass-masked `rs_busy`/`rt_busy`/`dst_busy`.
- **Top level:** the storage array, bypass muxes and `stall` AND-OR.

## Test plan
- **Reset and register 0:** assert `rst` for 2 cycles, then read regs 0..31 → all data 0, all busy 0. Then write `wa=0`, `wd=32'hFFFF_FFFF` → `reg[0]` still reads 0.
- **Write/read and bypass:**
  - Write `wa=5`, `wd=32'h1234_5678`, with `rs_addr=5` in the same cycle → `rs_data=32'h1234_5678` that cycle.
  - After the edge with `we=0` → still `32'h1234_5678`.
- **RAW stall:**
  - Issue `iss_dst=7` (accepted).
  - Next cycle, `iss_valid` with `rs_addr=7` → `rs_busy=1`, `stall=1`.
  - Writeback `wa=7` in the following cycle → `rs_busy=0`, `stall=0`, `rs_data=wd`.
- **WAW and set-wins:**
  - With reg 9 busy, issue `iss_dst=9` → `stall=1`.
  - In the cycle with `we`/`wa=9` and issue `iss_dst=9` → accepted. `busy[9]` is 1 after the edge.
- **Flush:**
  - Make regs 3, 4 and 10 busy.
  - Assert `flush` together with an accepted issue `iss_dst=12` → all busy 0 after the edge, including 12.
- **Reset mid-operation:**
  - With regs 2 and 6 busy and `reg[2]=32'hA5A5_A5A5`, assert `rst` for 1 cycle with `we=1`, `wa=2` → `reg[2]=0`.
  - Busy is 0 and `stall=0` afterward.
